// File: rtl/adc_stream_unpacker.sv
`default_nettype none
// ============================================================================
//  Module      : adc_stream_unpacker
//  Description : AXI-Stream slave for the 32-bit ADC capture stream. Checks
//                framing, sign-extends A/B into a FIFO and exposes counters.
//                Optional length check: define ADC_UNPACK_LEN_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_stream_unpacker #(
    parameter int FIFO_AW   = 4,
    parameter int OUT_WIDTH = 16
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic [31:0]          s_axis_tdata,
    input  logic                 s_axis_tvalid,
    input  logic                 s_axis_tlast,
    output logic                 s_axis_tready,
    output logic [OUT_WIDTH-1:0] m_sample_a,
    output logic [OUT_WIDTH-1:0] m_sample_b,
    output logic                 m_sample_first,
    output logic                 m_sample_last,
    output logic                 m_sample_err,
    output logic                 m_sample_valid,
    input  logic                 m_sample_ready,
    input  logic                 clear_stats,
    input  logic [7:0]           len_log2,
    output logic [31:0]          packets_count,
    output logic [31:0]          words_count,
    output logic [15:0]          tag_err_count,
    output logic [15:0]          tlast_err_count,
    output logic [15:0]          len_err_count,
    output logic [FIFO_AW:0]     fifo_level
);

    localparam logic [FIFO_AW:0] c_depth = (FIFO_AW+1)'(1 << FIFO_AW);
    localparam int               c_ew    = 2*OUT_WIDTH + 3;

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_pkt  = 1'b1;

    logic [0:0]           r_state;
    logic                 r_tready;
    logic [FIFO_AW:0]     r_level;
    logic [FIFO_AW-1:0]   r_wr_ptr;
    logic [FIFO_AW-1:0]   r_rd_ptr;
    logic [c_ew-1:0]      r_mem [0:(1<<FIFO_AW)-1];
    logic [31:0]          r_packets;
    logic [31:0]          r_words;
    logic [15:0]          r_tag_err;
    logic [15:0]          r_tlast_err;
    logic [15:0]          r_len_err;

    logic                 w_accept;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_first;
    logic                 w_tlast_mis;
    logic                 w_len_err;
    logic [FIFO_AW:0]     w_level_next;
    logic [OUT_WIDTH-1:0] w_a;
    logic [OUT_WIDTH-1:0] w_b;
    logic [c_ew-1:0]      w_wr_entry;
    logic [c_ew-1:0]      w_head;

    // Dropped words (bit31 = 0) count as accepted but never reach the FIFO or the FSM
    assign w_accept    = s_axis_tvalid & r_tready;
    assign w_push      = w_accept & s_axis_tdata[31];
    assign w_pop       = (r_level != '0) & m_sample_ready;
    assign w_first     = (r_state == c_st_idle);
    assign w_tlast_mis = (s_axis_tdata[30] != s_axis_tlast);

    assign w_a        = OUT_WIDTH'($signed(s_axis_tdata[29:15]));
    assign w_b        = OUT_WIDTH'($signed(s_axis_tdata[14:0]));
    assign w_wr_entry = {w_a, w_b, w_first, s_axis_tlast, w_tlast_mis | w_len_err};

`ifdef ADC_UNPACK_LEN_CHECK_EN
    logic [63:0] r_pos;
    logic [5:0]  r_len_sh;
    logic        r_len_chk;
    logic [63:0] w_pos;
    logic [63:0] w_target;
    logic [5:0]  w_len_sh;
    logic        w_len_chk;

    // The length setting is latched at the first word so it cannot change mid-packet
    assign w_len_chk = w_first ? (len_log2 < 8'd64) : r_len_chk;
    assign w_len_sh  = w_first ? len_log2[5:0] : r_len_sh;
    assign w_pos     = w_first ? 64'd1 : (r_pos + 64'd1);
    assign w_target  = 64'd1 << w_len_sh;
    assign w_len_err = w_push & w_len_chk &
                       (s_axis_tlast ? (w_pos < w_target) : (w_pos == w_target));

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_pos     <= '0;
            r_len_sh  <= '0;
            r_len_chk <= 1'b0;
        end else if (w_push) begin
            r_pos <= w_pos;
            if (w_first) begin
                r_len_sh  <= w_len_sh;
                r_len_chk <= w_len_chk;
            end
        end
    end
`else
    logic w_unused_len;
    assign w_unused_len = ^len_log2;
    assign w_len_err    = 1'b0;
`endif

    always_comb begin
        w_level_next = r_level;
        if (w_push && !w_pop) begin
            w_level_next = r_level + 1'b1;
        end else if (!w_push && w_pop) begin
            w_level_next = r_level - 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state  <= c_st_idle;
            r_tready <= 1'b0;
            r_level  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_level  <= w_level_next;
            r_tready <= (w_level_next < c_depth);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_state  <= s_axis_tlast ? c_st_idle : c_st_pkt;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset || clear_stats) begin
            r_packets   <= '0;
            r_words     <= '0;
            r_tag_err   <= '0;
            r_tlast_err <= '0;
            r_len_err   <= '0;
        end else begin
            if (w_push && s_axis_tlast) begin
                r_packets <= r_packets + 32'd1;
            end
            if (w_accept) begin
                r_words <= r_words + 32'd1;
            end
            if (w_accept && !s_axis_tdata[31] && r_tag_err != 16'hFFFF) begin
                r_tag_err <= r_tag_err + 16'd1;
            end
            if (w_push && w_tlast_mis && r_tlast_err != 16'hFFFF) begin
                r_tlast_err <= r_tlast_err + 16'd1;
            end
            if (w_len_err && r_len_err != 16'hFFFF) begin
                r_len_err <= r_len_err + 16'd1;
            end
        end
    end

    assign w_head         = r_mem[r_rd_ptr];
    assign m_sample_a     = w_head[OUT_WIDTH+3 +: OUT_WIDTH];
    assign m_sample_b     = w_head[3 +: OUT_WIDTH];
    assign m_sample_first = w_head[2];
    assign m_sample_last  = w_head[1];
    assign m_sample_err   = w_head[0];
    assign m_sample_valid = (r_level != '0);

    assign s_axis_tready   = r_tready;
    assign fifo_level      = r_level;
    assign packets_count   = r_packets;
    assign words_count     = r_words;
    assign tag_err_count   = r_tag_err;
    assign tlast_err_count = r_tlast_err;
    assign len_err_count   = r_len_err;

endmodule
`default_nettype wire

// File: tb/tb_adc_stream_unpacker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_stream_unpacker
//  Description : Scoreboard bench for adc_stream_unpacker (16-deep, 16-bit).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_stream_unpacker;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        first;
        logic        last;
        logic        err;
    } exp_t;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic [15:0] m_sample_a;
    logic [15:0] m_sample_b;
    logic        m_sample_first;
    logic        m_sample_last;
    logic        m_sample_err;
    logic        m_sample_valid;
    logic        m_sample_ready;
    logic        clear_stats;
    logic [7:0]  len_log2;
    logic [31:0] packets_count;
    logic [31:0] words_count;
    logic [15:0] tag_err_count;
    logic [15:0] tlast_err_count;
    logic [15:0] len_err_count;
    logic [4:0]  fifo_level;

    int   n_asserts = 0;
    int   n_fail    = 0;
    exp_t sb[$];

    logic [31:0] exp_packets, exp_words;
    logic [15:0] exp_tag, exp_tlast, exp_len;
    logic        in_pkt;
    logic [7:0]  m_len;
    logic [63:0] m_pos;

    adc_stream_unpacker #(.FIFO_AW(4), .OUT_WIDTH(16)) dut (
        .aclk            (aclk),
        .areset          (areset),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tready   (s_axis_tready),
        .m_sample_a      (m_sample_a),
        .m_sample_b      (m_sample_b),
        .m_sample_first  (m_sample_first),
        .m_sample_last   (m_sample_last),
        .m_sample_err    (m_sample_err),
        .m_sample_valid  (m_sample_valid),
        .m_sample_ready  (m_sample_ready),
        .clear_stats     (clear_stats),
        .len_log2        (len_log2),
        .packets_count   (packets_count),
        .words_count     (words_count),
        .tag_err_count   (tag_err_count),
        .tlast_err_count (tlast_err_count),
        .len_err_count   (len_err_count),
        .fifo_level      (fifo_level)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] sext15(input logic [14:0] x);
        return {x[14], x};
    endfunction

    function automatic logic [31:0] mkw(input logic [1:0] tag, input logic [14:0] a, input logic [14:0] b);
        return {tag, a, b};
    endfunction

    task automatic model_reset();
        exp_packets = '0; exp_words = '0;
        exp_tag = '0; exp_tlast = '0; exp_len = '0;
        in_pkt = 1'b0; m_len = '0; m_pos = '0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the word is taken
    task automatic send(input logic [31:0] d, input logic l);
        logic first, mis, lerr;
        logic [63:0] tgt;
        bit   done;
        done = 0;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge aclk);
            if (s_axis_tready) begin
                exp_words++;
                if (!d[31]) begin
                    exp_tag++;
                end else begin
                    first = !in_pkt;
                    mis   = (d[30] != l);
                    lerr  = 1'b0;
                    tgt   = '0;
`ifdef ADC_UNPACK_LEN_CHECK_EN
                    if (first) begin
                        m_len = len_log2;
                        m_pos = 64'd1;
                    end else begin
                        m_pos = m_pos + 64'd1;
                    end
                    if (m_len < 8'd64) begin
                        tgt  = 64'd1 << m_len[5:0];
                        lerr = l ? (m_pos < tgt) : (m_pos == tgt);
                    end
`endif
                    if (mis)  exp_tlast++;
                    if (lerr) exp_len++;
                    sb.push_back('{a: sext15(d[29:15]), b: sext15(d[14:0]),
                                   first: first, last: l, err: mis | lerr});
                    in_pkt = !l;
                    if (l) exp_packets++;
                end
                done = 1;
            end
            @(posedge aclk);
            #1;
        end
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic idle();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        bit done;
        done = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge aclk);
            if (sb.size() == 0 && !m_sample_valid) done = 1;
        end
        if (!done) check(tag, 0, 1);
        @(posedge aclk);
        #1;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_packets"}, packets_count, exp_packets);
        check({tag, "_words"},   words_count,   exp_words);
        check({tag, "_tagerr"},  tag_err_count, exp_tag);
        check({tag, "_tlerr"},   tlast_err_count, exp_tlast);
        check({tag, "_lenerr"},  len_err_count, exp_len);
    endtask

    // Scoreboard: a pop happens at the posedge following a negedge with valid & ready
    initial begin
        exp_t e;
        forever begin
            @(negedge aclk);
            if (m_sample_valid && m_sample_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("sample_a", m_sample_a, e.a);
                    check("sample_b", m_sample_b, e.b);
                    check("sample_flags", {m_sample_first, m_sample_last, m_sample_err},
                          {e.first, e.last, e.err});
                end
            end
        end
    end

    initial begin
        areset         = 1'b1;
        s_axis_tdata   = '0;
        s_axis_tvalid  = 1'b0;
        s_axis_tlast   = 1'b0;
        m_sample_ready = 1'b0;
        clear_stats    = 1'b0;
        len_log2       = 8'd255;
        model_reset();

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_tready", s_axis_tready, 0);
        check("rst_valid",  m_sample_valid, 0);
        check("rst_level",  fifo_level, 0);
        check_counters("rst");
        @(posedge aclk);
        #1 areset = 1'b0;
        @(posedge aclk);
        #1;
        check("rst_tready_after", s_axis_tready, 1);

        // Basic 4-word packet including the decode corner values
        m_sample_ready = 1'b1;
        send(32'h8000_4001, 1'b0);
        send(32'hBFFF_8000, 1'b0);
        send(mkw(2'b10, 15'h1234, 15'h7FFF), 1'b0);
        send(mkw(2'b11, 15'h4000, 15'h0001), 1'b1);
        idle();
        wait_drain("drain_basic");
        check("basic_packets", packets_count, 32'd1);
        check("basic_words",   words_count,   32'd4);
        check_counters("basic");

        // Backpressure: fill to 16, then release ready
        m_sample_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send(mkw(2'b10, 15'(i * 7), 15'(16'h7000 - i)), 1'b0);
        end
        check("full_tready", s_axis_tready, 0);
        check("full_level",  fifo_level, 5'd16);
        fork
            begin
                for (int i = 16; i < 20; i++) begin
                    send(mkw((i == 19) ? 2'b11 : 2'b10, 15'(i * 7), 15'(16'h7000 - i)), i == 19);
                end
                idle();
            end
            begin
                repeat (3) @(posedge aclk);
                #1;
                check("full_level_hold", fifo_level, 5'd16);
                m_sample_ready = 1'b1;
                @(negedge aclk);
                check("tready_still_low", s_axis_tready, 0);
                @(negedge aclk);
                check("tready_return", s_axis_tready, 1);
            end
        join
        wait_drain("drain_bp");
        check_counters("bp");

        // Dropped tag word mid-packet and a tag/tlast mismatch
        send(mkw(2'b10, 15'h0011, 15'h0022), 1'b0);
        send(mkw(2'b01, 15'h0033, 15'h0044), 1'b0);
        send(mkw(2'b11, 15'h0055, 15'h0066), 1'b0);
        send(mkw(2'b11, 15'h0077, 15'h0088), 1'b1);
        idle();
        wait_drain("drain_err");
        check("err_tagerr",  tag_err_count,   16'd1);
        check("err_tlerr",   tlast_err_count, 16'd1);
        check_counters("err");

        // clear_stats coincident with a tlast accept wins
        send(mkw(2'b10, 15'h0100, 15'h0200), 1'b0);
        clear_stats = 1'b1;
        send(mkw(2'b11, 15'h0300, 15'h0400), 1'b1);
        clear_stats = 1'b0;
        idle();
        exp_packets = '0; exp_words = '0;
        exp_tag = '0; exp_tlast = '0; exp_len = '0;
        check("clr_packets", packets_count, 0);
        check_counters("clr");
        wait_drain("drain_clr");

        // Reset mid-packet with samples still buffered
        m_sample_ready = 1'b0;
        send(mkw(2'b10, 15'h0AAA, 15'h0555), 1'b0);
        send(mkw(2'b10, 15'h0BBB, 15'h0666), 1'b0);
        idle();
        areset = 1'b1;
        sb.delete();
        model_reset();
        @(posedge aclk);
        #1;
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_valid", m_sample_valid, 0);
        areset = 1'b0;
        @(posedge aclk);
        #1;
        m_sample_ready = 1'b1;
        send(mkw(2'b11, 15'h0CCC, 15'h0777), 1'b1);
        idle();
        wait_drain("drain_rst");
        check_counters("rst2");

`ifdef ADC_UNPACK_LEN_CHECK_EN
        len_log2 = 8'd3;
        for (int i = 0; i < 5; i++) send(mkw(i == 4 ? 2'b11 : 2'b10, 15'(i), 15'(i + 1)), i == 4);
        for (int i = 0; i < 8; i++) send(mkw(i == 7 ? 2'b11 : 2'b10, 15'(i), 15'(i + 2)), i == 7);
        idle();
        wait_drain("drain_len");
        check("len_err_one", len_err_count, 16'd1);
        len_log2 = 8'd64;
        for (int i = 0; i < 5; i++) send(mkw(i == 4 ? 2'b11 : 2'b10, 15'(i), 15'(i + 3)), i == 4);
        idle();
        wait_drain("drain_len64");
        check_counters("len");
`endif

        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
